// File: rtl/compute_tile_pkg.sv
// Shared opcode encodings and signed clamp helpers for the compute tile.
// Latency: n/a (package, pure combinational helpers).
// Backpressure: n/a.
// Helpers work on a 64-bit signed scratch type. Callers sign-extend their operands
// into it, so every width passed in must be <= 63.
package compute_tile_pkg;

    localparam logic [3:0] OP_NOT    = 4'd0;
    localparam logic [3:0] OP_AND    = 4'd1;
    localparam logic [3:0] OP_OR     = 4'd2;
    localparam logic [3:0] OP_ADD    = 4'd3;
    localparam logic [3:0] OP_LTU    = 4'd4;
    localparam logic [3:0] OP_GTU    = 4'd5;
    localparam logic [3:0] OP_EQ     = 4'd6;
    localparam logic [3:0] OP_MUL    = 4'd7;
    localparam logic [3:0] OP_READ   = 4'd8;
    localparam logic [3:0] OP_LOADC  = 4'd9;
    localparam logic [3:0] OP_ADDS   = 4'd10;
    localparam logic [3:0] OP_SUBS   = 4'd11;
    localparam logic [3:0] OP_LTS    = 4'd12;
    localparam logic [3:0] OP_GTS    = 4'd13;
    localparam logic [3:0] OP_ACCCLR = 4'd14;
    localparam logic [3:0] OP_MAC    = 4'd15;

    localparam int CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Largest positive value of a w-bit two's-complement number.
    function automatic calc_t smax(input int w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    // Most negative value of a w-bit two's-complement number.
    function automatic calc_t smin(input int w);
        return ~smax(w);
    endfunction

    function automatic logic over_range(input calc_t v, input int w);
        return (v > smax(w)) || (v < smin(w));
    endfunction

    function automatic calc_t clamp(input calc_t v, input int w);
        if (v > smax(w)) begin
            return smax(w);
        end
        if (v < smin(w)) begin
            return smin(w);
        end
        return v;
    endfunction

    function automatic calc_t sat_add(input calc_t a, input calc_t b, input int w);
        return clamp(a + b, w);
    endfunction

endpackage

// File: rtl/compute_tile_pipe_if.sv
// Request/response handshake bundle of one compute tile.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry the stall in each direction.
// Ports: in_* request beat (valid/ready, opcode, operands, cache select),
//        out_* result beat (valid/ready, data, saturation flag).
interface compute_tile_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_use_cache;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;

    // Requester / result consumer side.
    modport master (
        output in_valid, in_opcode, in_a, in_b, in_use_cache, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    // Tile side.
    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_use_cache, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/tile_mac_unit.sv
// Signed multiply plus saturating ACC_WIDTH accumulator for the MAC opcode.
// Latency: acc_next is combinational from acc_q/a/b; acc_q updates on the clock edge with en or clr.
// Backpressure: none; the owner only pulses en/clr on the beat's commit edge.
// Ports: clk, clear_n (async reset), en (accumulate), clr (zero, wins over en),
//        a/b signed operands, acc_next (clamped new value), acc_sat (clamp happened).
module tile_mac_unit
    import compute_tile_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [ACC_WIDTH-1:0] acc_next,
    output logic                 acc_sat
);

    logic [ACC_WIDTH-1:0]     acc_q;
    logic [ACC_WIDTH-1:0]     acc_d;
    logic signed [2*WIDTH-1:0] prod;
    calc_t                    sum;

    always_comb begin
        prod     = signed'(a) * signed'(b);
        // The exact sum is formed in the wide scratch type so the clamp sees the true value.
        sum      = calc_t'(signed'(acc_q)) + calc_t'(prod);
        acc_sat  = over_range(sum, ACC_WIDTH);
        acc_next = ACC_WIDTH'(clamp(sum, ACC_WIDTH));
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/compute_tile_pipe.sv
// Two-stage compute tile: S1 registers opcode/A/effective-B, S2 computes and registers the result.
// Latency: 2 cycles from the accept cycle to out_valid; 1 beat/cycle when out_ready stays high.
// Backpressure: the whole pipe advances only when the output slot is empty or being taken; in_ready = same term.
// Ports: clk, clear_n (async active-low reset), io (slave side of compute_tile_pipe_if).
module compute_tile_pipe
    import compute_tile_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40
) (
    input  logic                clk,
    input  logic                clear_n,
    compute_tile_pipe_if.slave  io
);

    // S1 stage
    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    // S2 stage / output slot
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    // Architectural state
    logic [WIDTH-1:0] result_reg_q, result_reg_d;
    logic [WIDTH-1:0] cache_q, cache_d;

    logic             advance;
    logic             commit;
    logic             mac_en;
    logic             mac_clr;
    logic [ACC_WIDTH-1:0] acc_next;
    logic             acc_sat;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_sat;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH:0]     add_u;
    calc_t              sa;
    calc_t              sb;
    calc_t              sacc;
    calc_t              adds_sum;
    calc_t              subs_diff;

    tile_mac_unit #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .clear_n  (clear_n),
        .en       (mac_en),
        .clr      (mac_clr),
        .a        (s1_a_q),
        .b        (s1_b_q),
        .acc_next (acc_next),
        .acc_sat  (acc_sat)
    );

    // S2 datapath: operates on the S1 registers.
    always_comb begin
        alu_res   = '0;
        alu_sat   = 1'b0;
        sa        = calc_t'(signed'(s1_a_q));
        sb        = calc_t'(signed'(s1_b_q));
        sacc      = calc_t'(signed'(acc_next));
        prod_u    = (2*WIDTH)'(s1_a_q) * (2*WIDTH)'(s1_b_q);
        add_u     = (WIDTH+1)'(s1_a_q) + (WIDTH+1)'(s1_b_q);
        adds_sum  = sa + sb;
        subs_diff = sa - sb;
        case (s1_op_q)
            OP_NOT:    alu_res = ~s1_a_q;
            OP_AND:    alu_res = s1_a_q & s1_b_q;
            OP_OR:     alu_res = s1_a_q | s1_b_q;
            OP_ADD: begin
                alu_res = add_u[WIDTH-1:0];
                alu_sat = add_u[WIDTH];
            end
            OP_LTU:    alu_res = WIDTH'(s1_a_q < s1_b_q);
            OP_GTU:    alu_res = WIDTH'(s1_a_q > s1_b_q);
            OP_EQ:     alu_res = WIDTH'(s1_a_q == s1_b_q);
            OP_MUL: begin
                alu_res = prod_u[WIDTH-1:0];
                alu_sat = |prod_u[2*WIDTH-1:WIDTH];
            end
            OP_READ:   alu_res = result_reg_q;
            OP_LOADC:  alu_res = s1_a_q;
            OP_ADDS: begin
                alu_res = WIDTH'(sat_add(sa, sb, WIDTH));
                alu_sat = over_range(adds_sum, WIDTH);
            end
            OP_SUBS: begin
                alu_res = WIDTH'(sat_add(sa, -sb, WIDTH));
                alu_sat = over_range(subs_diff, WIDTH);
            end
            OP_LTS:    alu_res = WIDTH'(sa < sb);
            OP_GTS:    alu_res = WIDTH'(sa > sb);
            OP_ACCCLR: alu_res = '0;
            OP_MAC: begin
                // Output is the new accumulator narrowed to WIDTH; either clamp flags the beat.
                alu_res = WIDTH'(clamp(sacc, WIDTH));
                alu_sat = acc_sat | over_range(sacc, WIDTH);
            end
            default: ;
        endcase
    end

    // Pipeline control, cache and result register.
    always_comb begin
        advance      = !out_valid_q || io.out_ready;
        // A beat commits (updates acc/cache/result_reg) exactly once: on the edge it moves S1 -> S2.
        commit       = advance && s1_valid_q;
        mac_en       = commit && (s1_op_q == OP_MAC);
        mac_clr      = commit && (s1_op_q == OP_ACCCLR);

        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sat_d    = out_sat_q;
        result_reg_d = result_reg_q;
        cache_d      = cache_q;

        if (advance) begin
            s1_valid_d = io.in_valid;
            if (io.in_valid) begin
                s1_op_d = io.in_opcode;
                s1_a_d  = io.in_a;
                // Reads the registered cache, so a LOADC committing on this same edge is not seen.
                s1_b_d  = io.in_use_cache ? cache_q : io.in_b;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = alu_res;
                out_sat_d  = alu_sat;
                if (s1_op_q != OP_READ) begin
                    result_reg_d = alu_res;
                end
                if (s1_op_q == OP_LOADC) begin
                    cache_d = s1_a_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sat_q    <= 1'b0;
            result_reg_q <= '0;
            cache_q      <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sat_q    <= out_sat_d;
            result_reg_q <= result_reg_d;
            cache_q      <= cache_d;
        end
    end

    assign io.in_ready  = advance;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_sat   = out_sat_q;

endmodule

// File: tb/tb_compute_tile_pipe.sv
// Self-checking bench for compute_tile_pipe: table-driven opcode vectors plus hand sequences.
// Latency: n/a.
// Backpressure: optional random out_ready while the table is replayed.
module tb_compute_tile_pipe;
    import compute_tile_pkg::*;

    localparam int W  = 16;
    localparam int AW = 40;

    logic clk = 1'b0;
    logic clear_n;
    always #5 clk = ~clk;

    compute_tile_pipe_if #(.WIDTH(W)) tif ();

    compute_tile_pipe #(
        .WIDTH     (W),
        .ACC_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .io      (tif)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_d;
        logic         exp_s;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   bp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] d, input logic s);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_d = d; v.exp_s = s;
        tbl.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge,
    // leaving in_valid high so consecutive calls issue back-to-back beats.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic uc, input logic [W-1:0] d, input logic s);
        exp_t e;
        int   n = 0;
        tif.in_valid     = 1'b1;
        tif.in_opcode    = op;
        tif.in_a         = a;
        tif.in_b         = b;
        tif.in_use_cache = uc;
        if (bp_en) tif.out_ready = 1'($urandom_range(0, 1));
        #1;
        while (!tif.in_ready && n < 100) begin
            @(negedge clk);
            n++;
            if (bp_en) tif.out_ready = 1'($urandom_range(0, 1));
            #1;
        end
        if (!tif.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stuck at %0b, want 1 (op %0d)", tif.in_ready, op);
        end else begin
            e.d = d;
            e.s = s;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        tif.in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        tif.in_valid  = 1'b0;
        tif.out_ready = 1'b1;
        bp_en         = 1'b0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding, want 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    // Scoreboard monitor: samples mid-low-phase, after the driver has settled its inputs.
    logic         pend_stall = 1'b0;
    logic [W-1:0] pend_d;
    logic         pend_s;
    always @(negedge clk) begin : mon
        exp_t e;
        #2;
        if (pend_stall && clear_n) begin
            check("hold_valid", 64'(tif.out_valid), 64'd1);
            check("hold_data", 64'(tif.out_data), 64'(pend_d));
            check("hold_sat", 64'(tif.out_sat), 64'(pend_s));
        end
        if (clear_n && tif.out_valid && tif.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_out: got data 0x%0h, want no beat", tif.out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(tif.out_data), 64'(e.d));
                check("out_sat", 64'(tif.out_sat), 64'(e.s));
            end
        end
        pend_stall = clear_n && tif.out_valid && !tif.out_ready;
        pend_d     = tif.out_data;
        pend_s     = tif.out_sat;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        add_vec(OP_NOT,  16'h00FF, 16'h0000, 16'hFF00, 1'b0);
        add_vec(OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 1'b0);
        add_vec(OP_OR,   16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0);
        add_vec(OP_ADD,  16'h1234, 16'h1111, 16'h2345, 1'b0);
        add_vec(OP_ADD,  16'hFFFF, 16'h0002, 16'h0001, 1'b1);
        add_vec(OP_LTU,  16'h0003, 16'h0005, 16'h0001, 1'b0);
        add_vec(OP_GTU,  16'h0003, 16'h0005, 16'h0000, 1'b0);
        add_vec(OP_EQ,   16'h0007, 16'h0007, 16'h0001, 1'b0);
        add_vec(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 1'b1);
        add_vec(OP_MUL,  16'h00FF, 16'h0002, 16'h01FE, 1'b0);
        add_vec(OP_ADDS, 16'h7FF0, 16'h0020, 16'h7FFF, 1'b1);
        add_vec(OP_SUBS, 16'h8000, 16'h0001, 16'h8000, 1'b1);
        add_vec(OP_ADDS, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        add_vec(OP_ADDS, 16'h8000, 16'hFFFF, 16'h8000, 1'b1);
        add_vec(OP_SUBS, 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
        add_vec(OP_LTS,  16'hFFFF, 16'h0001, 16'h0001, 1'b0);
        add_vec(OP_LTU,  16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        add_vec(OP_READ, 16'h1234, 16'h5678, 16'h0000, 1'b0);
        add_vec(OP_GTS,  16'h0001, 16'hFFFF, 16'h0001, 1'b0);
        add_vec(OP_GTS,  16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        add_vec(OP_NOT,  16'h0000, 16'h0000, 16'hFFFF, 1'b0);
        add_vec(OP_READ, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
        add_vec(OP_READ, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
        add_vec(OP_EQ,   16'h0007, 16'h0008, 16'h0000, 1'b0);
        add_vec(OP_GTU,  16'hFFFF, 16'h0001, 16'h0001, 1'b0);
        add_vec(OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);

        tif.in_valid     = 1'b0;
        tif.in_opcode    = '0;
        tif.in_a         = '0;
        tif.in_b         = '0;
        tif.in_use_cache = 1'b0;
        tif.out_ready    = 1'b1;
        clear_n          = 1'b1;
        #1 clear_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(tif.out_valid), 64'd0);
        check("rst_out_data", 64'(tif.out_data), 64'd0);
        check("rst_out_sat", 64'(tif.out_sat), 64'd0);
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(tif.in_ready), 64'd1);
        check("rst_acc", 64'(dut.u_mac.acc_q), 64'd0);
        check("rst_cache", 64'(dut.cache_q), 64'd0);
        check("rst_result_reg", 64'(dut.result_reg_q), 64'd0);

        // Accept-to-valid latency on a wrapping ADD.
        send(OP_ADD, 16'hFFFF, 16'h0002, 1'b0, 16'h0001, 1'b1);
        tif.in_valid = 1'b0;
        check("lat_cycle1_valid", 64'(tif.out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 64'(tif.out_valid), 64'd1);
        drain();

        // Opcode table, first with a free-running sink, then with random backpressure.
        for (int pass = 0; pass < 2; pass++) begin
            bp_en = (pass == 1);
            foreach (tbl[i]) send(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, tbl[i].exp_d, tbl[i].exp_s);
            drain();
        end

        // Cache: load, use after commit, then LOADC in S2 racing a cache read into S1.
        send(OP_LOADC, 16'h0003, 16'h0000, 1'b0, 16'h0003, 1'b0);
        idle(2);
        send(OP_MUL, 16'h0005, 16'hAAAA, 1'b1, 16'h000F, 1'b0);
        idle(2);
        send(OP_LOADC, 16'h0007, 16'h0000, 1'b0, 16'h0007, 1'b0);
        send(OP_MUL, 16'h0005, 16'hAAAA, 1'b1, 16'h000F, 1'b0);
        idle(2);
        send(OP_MUL, 16'h0005, 16'hAAAA, 1'b1, 16'h0023, 1'b0);
        drain();
        check("cache_after_loadc", 64'(dut.cache_q), 64'h7);

        // MAC chain, then a stall with one committed MAC in S2 and another waiting in S1.
        send(OP_ACCCLR, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) send(OP_MAC, 16'h0100, 16'h0100, 1'b0, 16'h7FFF, 1'b1);
        drain();
        check("acc_after_3mac", 64'(dut.u_mac.acc_q), 64'h30000);
        tif.out_ready = 1'b0;
        send(OP_MAC, 16'h0100, 16'h0100, 1'b0, 16'h7FFF, 1'b1);
        send(OP_MAC, 16'h0100, 16'h0100, 1'b0, 16'h7FFF, 1'b1);
        tif.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", 64'(tif.in_ready), 64'd0);
            check("stall_acc", 64'(dut.u_mac.acc_q), 64'h40000);
            @(negedge clk);
        end
        drain();
        check("acc_after_stall", 64'(dut.u_mac.acc_q), 64'h50000);

        // Asynchronous clear with two beats in flight.
        tif.out_ready = 1'b0;
        send(OP_NOT, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        send(OP_AND, 16'hFFFF, 16'h00FF, 1'b0, 16'h00FF, 1'b0);
        tif.in_valid = 1'b0;
        #3 clear_n = 1'b0;
        #1;
        check("clr_out_valid", 64'(tif.out_valid), 64'd0);
        check("clr_s1_valid", 64'(dut.s1_valid_q), 64'd0);
        check("clr_acc", 64'(dut.u_mac.acc_q), 64'd0);
        check("clr_cache", 64'(dut.cache_q), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        clear_n       = 1'b1;
        tif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_clr_no_beat", 64'(tif.out_valid), 64'd0);
        end
        send(OP_READ, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        send(OP_MUL, 16'h0005, 16'h1111, 1'b1, 16'h0000, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
